// File: rtl/alpaca_constants_pkg.sv
// Shared types, defaults and shift arithmetic for the oversampled-PFB phase compensator.
package alpaca_constants_pkg;

    typedef enum logic {FILLA, FILLB} phasecomp_state_t;

    localparam int unsigned DefaultWidth  = 16;
    localparam int unsigned DefaultFftLen = 32;
    localparam int unsigned DefaultDecFac = 24;

    // (s + d) mod m for s, d < m; one conditional subtract, no divider.
    function automatic int unsigned phasecomp_next_shift(input int unsigned s,
                                                         input int unsigned d,
                                                         input int unsigned m);
        int unsigned sum;
        sum = s + d;
        return (sum >= m) ? sum - m : sum;
    endfunction

endpackage

// File: rtl/phasecomp_bank_ram.sv
// Two-bank sample store: one synchronous write port, one asynchronous read port.
module phasecomp_bank_ram #(
    parameter int unsigned DW = 32,
    parameter int unsigned M  = 32,
    parameter int unsigned AW = $clog2(M)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic          i_wbank,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_rbank,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    localparam int unsigned FW   = AW + 1;
    localparam bit          Pow2 = (M == (1 << AW));

    logic [DW-1:0] r_mem [2*M];
    logic [FW-1:0] w_wfull;
    logic [FW-1:0] w_rfull;

    if (Pow2) begin : g_pow2
        assign w_wfull = {i_wbank, i_waddr};
        assign w_rfull = {i_rbank, i_raddr};
    end else begin : g_npow2
        assign w_wfull = i_wbank ? FW'(M) + {1'b0, i_waddr} : {1'b0, i_waddr};
        assign w_rfull = i_rbank ? FW'(M) + {1'b0, i_raddr} : {1'b0, i_raddr};
    end

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[w_wfull] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[w_rfull];

endmodule

// File: rtl/ospfb_phasecomp_pp.sv
// Ping-pong phase-compensation buffer: rotates each FFT_LEN frame by a shift advancing by DEC_FAC.
module ospfb_phasecomp_pp
    import alpaca_constants_pkg::*;
#(
    parameter int unsigned WIDTH   = DefaultWidth,
    parameter int unsigned FFT_LEN = DefaultFftLen,
    parameter int unsigned DEC_FAC = DefaultDecFac
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [2*WIDTH-1:0]         s_axis_tdata,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    input  logic                       s_axis_tlast,
    input  logic                       bypass,
    output logic [2*WIDTH-1:0]         m_axis_tdata,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic                       m_axis_tlast,
    output logic [$clog2(FFT_LEN)-1:0] frame_shift,
    output logic                       tlast_err
);

    localparam int unsigned SW = $clog2(FFT_LEN);
    localparam int unsigned DW = 2 * WIDTH;
    localparam logic [SW-1:0] LastIdx = SW'(FFT_LEN - 1);

    if (FFT_LEN < 2) begin : g_bad_len
        $error("ospfb_phasecomp_pp: FFT_LEN must be at least 2");
    end
    if (DEC_FAC == 0 || DEC_FAC >= FFT_LEN) begin : g_bad_dec
        $error("ospfb_phasecomp_pp: DEC_FAC must satisfy 0 < DEC_FAC < FFT_LEN");
    end

    phasecomp_state_t r_state, w_state_next;
    logic [1:0]       r_full, w_full_next;
    logic             r_rb;
    logic             r_byp;
    logic [SW-1:0]    r_wcnt;
    logic [SW-1:0]    r_rcnt;
    logic [SW-1:0]    r_shift;
    logic [DW-1:0]    r_tdata;
    logic             r_tvalid;
    logic             r_tlast;
    logic             r_tlast_err;

    logic             w_wb;
    logic             w_in_hs;
    logic             w_in_last;
    logic             w_byp;
    logic [SW-1:0]    w_waddr;
    logic             w_load;
    logic             w_rd_last;
    logic [DW-1:0]    w_rdata;

    assign w_wb          = (r_state == FILLB);
    assign s_axis_tready = !r_full[w_wb];
    assign w_in_hs       = s_axis_tvalid && s_axis_tready;
    assign w_in_last     = (r_wcnt == LastIdx);
    // Bypass for sample 0 must come straight from the port; later samples use the latched copy.
    assign w_byp         = (r_wcnt == '0) ? bypass : r_byp;
    assign w_waddr       = w_byp ? r_wcnt
                                 : SW'(phasecomp_next_shift(32'(r_wcnt), 32'(r_shift), FFT_LEN));

    assign w_load    = (!r_tvalid || m_axis_tready) && r_full[r_rb];
    assign w_rd_last = (r_rcnt == LastIdx);

    always_comb begin
        w_state_next = r_state;
        if (w_in_hs && w_in_last) begin
            w_state_next = (r_state == FILLA) ? FILLB : FILLA;
        end
    end

    // Writer and reader always own different banks, so set and clear never hit the same flag.
    always_comb begin
        w_full_next = r_full;
        if (w_in_hs && w_in_last) begin
            w_full_next[w_wb] = 1'b1;
        end
        if (w_load && w_rd_last) begin
            w_full_next[r_rb] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FILLA;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_full      <= '0;
            r_rb        <= 1'b0;
            r_byp       <= 1'b0;
            r_wcnt      <= '0;
            r_rcnt      <= '0;
            r_shift     <= '0;
            r_tdata     <= '0;
            r_tvalid    <= 1'b0;
            r_tlast     <= 1'b0;
            r_tlast_err <= 1'b0;
        end else begin
            r_full      <= w_full_next;
            r_tlast_err <= w_in_hs && (s_axis_tlast != w_in_last);

            if (w_in_hs) begin
                if (r_wcnt == '0) begin
                    r_byp <= bypass;
                end
                if (w_in_last) begin
                    r_wcnt  <= '0;
                    r_shift <= SW'(phasecomp_next_shift(32'(r_shift), DEC_FAC, FFT_LEN));
                end else begin
                    r_wcnt <= r_wcnt + 1'b1;
                end
            end

            if (w_load) begin
                r_tdata  <= w_rdata;
                r_tvalid <= 1'b1;
                r_tlast  <= w_rd_last;
                if (w_rd_last) begin
                    r_rcnt <= '0;
                    r_rb   <= !r_rb;
                end else begin
                    r_rcnt <= r_rcnt + 1'b1;
                end
            end else if (m_axis_tready) begin
                r_tvalid <= 1'b0;
                r_tlast  <= 1'b0;
            end
        end
    end

    phasecomp_bank_ram #(
        .DW (DW),
        .M  (FFT_LEN),
        .AW (SW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_in_hs),
        .i_wbank (w_wb),
        .i_waddr (w_waddr),
        .i_wdata (s_axis_tdata),
        .i_rbank (r_rb),
        .i_raddr (r_rcnt),
        .o_rdata (w_rdata)
    );

    assign m_axis_tdata  = r_tdata;
    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tlast  = r_tlast;
    assign frame_shift   = r_shift;
    assign tlast_err     = r_tlast_err;

endmodule

// File: tb/tb_ospfb_phasecomp_pp.sv
// Bench for ospfb_phasecomp_pp: frame-level rotation model plus scoreboard, directed and random runs.
`timescale 1ns/1ps
module tb_ospfb_phasecomp_pp;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned M     = 32;
    localparam int unsigned D     = 24;
    localparam int unsigned SW    = $clog2(M);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   s_axis_tdata = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic          s_axis_tlast = 1'b0;
    logic          bypass = 1'b0;
    logic [31:0]   m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b1;
    logic          m_axis_tlast;
    logic [SW-1:0] frame_shift;
    logic          tlast_err;

    always #5 clk = ~clk;

    ospfb_phasecomp_pp #(
        .WIDTH   (WIDTH),
        .FFT_LEN (M),
        .DEC_FAC (D)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .bypass        (bypass),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .frame_shift   (frame_shift),
        .tlast_err     (tlast_err)
    );

    int n_vec = 0;
    int n_err = 0;
    bit abort = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Model: a completed input frame becomes M expected outputs, out[(i+s)%M] = in[i].
    logic [32:0] exp_q[$];
    logic [31:0] out_log[$];
    logic [31:0] fb[M];
    logic [32:0] e;
    int  m_i = 0, m_s = 0, lat = 0;
    bit  m_byp = 0, m_err_pend = 0, hold_prev = 0;
    logic [31:0] prev_d;
    logic        prev_l;
    int  acc_cnt = 0, err_pulses = 0;
    bit  phase_stream = 0;
    int  tr_gap = 0, tv_gap = 0, out_phase = 0;
    int  m_mode = 0;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            m_i = 0; m_s = 0; m_byp = 0; m_err_pend = 0; lat = 0; hold_prev = 0;
        end else begin
            chk("frame_shift", frame_shift, m_s);
            chk("tlast_err", tlast_err, m_err_pend);
            if (tlast_err) err_pulses++;
            if (lat == 2) begin
                chk("latency_early_valid", m_axis_tvalid, 0);
                lat = 1;
            end else if (lat == 1) begin
                chk("latency_valid", m_axis_tvalid, 1);
                lat = 0;
            end
            if (hold_prev) begin
                chk("hold_valid", m_axis_tvalid, 1);
                chk("hold_data", m_axis_tdata, prev_d);
                chk("hold_last", m_axis_tlast, prev_l);
            end
            if (exp_q.size() == 0) chk("idle_valid", m_axis_tvalid, 0);
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL out_extra: got %0h, expected no sample", m_axis_tdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", m_axis_tdata, e[31:0]);
                    chk("out_last", m_axis_tlast, e[32]);
                end
                out_log.push_back(m_axis_tdata);
                if (phase_stream) out_phase++;
            end
            hold_prev = m_axis_tvalid && !m_axis_tready;
            prev_d    = m_axis_tdata;
            prev_l    = m_axis_tlast;
            if (phase_stream) begin
                if (s_axis_tvalid && !s_axis_tready) tr_gap++;
                if (out_phase > 0 && out_phase < 10 * M && !m_axis_tvalid) tv_gap++;
            end

            m_err_pend = 0;
            if (s_axis_tvalid && s_axis_tready) begin
                acc_cnt++;
                m_err_pend = (s_axis_tlast != (m_i == M - 1));
                if (m_i == 0) m_byp = bypass;
                fb[(m_i + (m_byp ? 0 : m_s)) % M] = s_axis_tdata;
                m_i++;
                if (m_i == M) begin
                    if (exp_q.size() == 0) lat = 2;
                    for (int k = 0; k < M; k++) exp_q.push_back({(k == M - 1), fb[k]});
                    m_i = 0;
                    m_s = (m_s + D) % M;
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        case (m_mode)
            0:       m_axis_tready = 1'b1;
            1:       m_axis_tready = ($urandom_range(2) != 0);
            default: m_axis_tready = 1'b0;
        endcase
    end

    function automatic logic [31:0] get_out(input int idx);
        return (idx < out_log.size()) ? out_log[idx] : 32'hDEAD_BEEF;
    endfunction

    // Sample j of the run is frame j/M, index j%M; bad_idx flips tlast on one sample.
    task automatic drive(input logic [31:0] base, input int nsamp, input logic [31:0] byp_mask,
                         input int bad_idx, input bit rnd);
        for (int j = 0; j < nsamp && !abort; j++) begin
            int  n;
            int  i;
            int  waitc;
            bit  done;
            n = j / M;
            i = j % M;
            waitc = 0;
            done = 0;
            if (rnd) begin
                while ($urandom_range(3) == 0) begin
                    s_axis_tvalid = 1'b0;
                    @(posedge clk); #1;
                end
            end
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = rnd ? $urandom : base + 32'(n * 256 + i);
            s_axis_tlast  = (i == M - 1) ^ (j == bad_idx);
            bypass        = (i == 0) ? byp_mask[n] : 1'($urandom);
            while (!done) begin
                @(negedge clk);
                done = s_axis_tready;
                @(posedge clk); #1;
                if (!done) begin
                    waitc++;
                    if (waitc > 2000) begin
                        n_vec++; n_err++;
                        $display("FAIL input_timeout: tready low %0d cycles, expected a handshake", waitc);
                        abort = 1;
                        done = 1;
                    end
                end
            end
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        bypass        = 1'b0;
    endtask

    task automatic drain();
        int c;
        c = 0;
        while ((exp_q.size() != 0 || m_axis_tvalid) && c < 3000) begin
            @(posedge clk); #1;
            c++;
        end
        chk("drain_empty", exp_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input bit check);
        rst = 1'b1;
        s_axis_tvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        if (check) begin
            chk("rst_s_tready", s_axis_tready, 1);
            chk("rst_m_tvalid", m_axis_tvalid, 0);
            chk("rst_m_tlast", m_axis_tlast, 0);
            chk("rst_m_tdata", m_axis_tdata, 0);
            chk("rst_frame_shift", frame_shift, 0);
            chk("rst_tlast_err", tlast_err, 0);
        end
        rst = 1'b0;
        out_log.delete();
        acc_cnt = 0;
        err_pulses = 0;
    endtask

    initial begin
        // Continuous streaming of frames n*256+i.
        m_mode = 0;
        do_reset(1);
        phase_stream = 1;
        drive(32'h0, 10 * M, 32'h0, -1, 0);
        drain();
        phase_stream = 0;
        chk("stream_tready_gaps", tr_gap, 0);
        chk("stream_tvalid_gaps", tv_gap, 0);
        chk("stream_count", out_log.size(), 10 * M);
        chk("f0_k0", get_out(0), 0);
        chk("f0_k31", get_out(31), 31);
        chk("f1_k0", get_out(32), 264);
        chk("f1_k24", get_out(32 + 24), 256);
        chk("f2_k0", get_out(64), 528);
        chk("f3_k0", get_out(96), 792);
        chk("f4_k0", get_out(128), 1024);
        chk("f4_k5", get_out(133), 1029);
        chk("stream_final_shift", frame_shift, 16);

        // Output backpressure for 80 cycles.
        m_mode = 2;
        do_reset(0);
        fork
            drive(32'h1000_0000, 3 * M, 32'h0, -1, 0);
            begin
                repeat (80) @(posedge clk);
                #1;
                chk("bp_accepted", acc_cnt, 64);
                chk("bp_s_tready", s_axis_tready, 0);
                chk("bp_held_valid", m_axis_tvalid, 1);
                chk("bp_held_data", m_axis_tdata, 32'h1000_0000);
                m_mode = 0;
            end
        join
        drain();
        chk("bp_count", out_log.size(), 3 * M);
        chk("bp_f2_k0", get_out(64), 32'h1000_0210);

        // Bypass on frame 1 only.
        do_reset(0);
        drive(32'h0, 3 * M, 32'b010, -1, 0);
        drain();
        chk("byp_f1_k0", get_out(32), 256);
        chk("byp_f1_k31", get_out(63), 287);
        chk("byp_f2_k0", get_out(64), 528);
        chk("byp_f2_k31", get_out(95), 527);

        // Early tlast at i=10.
        do_reset(0);
        drive(32'h0, 2 * M, 32'h0, 10, 0);
        drain();
        chk("tlast_err_pulses", err_pulses, 1);
        chk("tlast_f0_k10", get_out(10), 10);
        chk("tlast_f1_k0", get_out(32), 264);

        // Reset mid-frame 2 with frame 1 still buffered.
        do_reset(0);
        drive(32'h0, 2 * M + 10, 32'h0, -1, 0);
        chk("pre_reset_valid", m_axis_tvalid, 1);
        do_reset(1);
        drive(32'h2000_0000, M, 32'h0, -1, 0);
        drain();
        chk("post_reset_count", out_log.size(), M);
        chk("post_reset_k0", get_out(0), 32'h2000_0000);
        chk("post_reset_k31", get_out(31), 32'h2000_001F);

        // Randomised traffic, bypass, backpressure and one bad tlast per round.
        for (int r = 0; r < 2; r++) begin
            m_mode = 1;
            do_reset(0);
            drive(32'h0, 12 * M, $urandom, $urandom_range(0, 12 * M - 1), 1);
            m_mode = 0;
            drain();
            chk("rand_count", out_log.size(), 12 * M);
            chk("rand_tlast_err_pulses", err_pulses, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
